// File: rtl/demux_pkg.sv
// Shared constants and channel-index type for the registered 1-to-4 demux.
package demux_pkg;
  localparam int unsigned N_OUT = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux1to4_reg_if.sv
// Stream interface of the 1-to-4 demux: one input stream fanned out to four channels.
interface demux1to4_reg_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
);
  import demux_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  sel_t                  in_sel;
  logic                  rr_en;
  logic [N_OUT-1:0]      out_valid;
  logic [N_OUT-1:0]      out_ready;
  logic [N_OUT*W-1:0]    out_data;
  sel_t                  rr_ptr;
  logic [CNT_W-1:0]      accept_cnt;

  modport master (
    output in_valid, in_data, in_sel, rr_en, out_ready,
    input  in_ready, out_valid, out_data, rr_ptr, accept_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, rr_en, out_ready,
    output in_ready, out_valid, out_data, rr_ptr, accept_cnt
  );
endinterface

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
module demux_slot #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain,
  output logic         valid,
  output logic [W-1:0] data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Load wins over drain so a same-cycle drain+load keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (drain) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer: steers one valid/ready stream into four holding slots,
// target chosen by in_sel or a round-robin pointer.
module demux1to4_reg
  import demux_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  demux1to4_reg_if.slave  bus
);
  sel_t               tgt_c;
  logic               in_ready_c;
  logic               accept_c;
  logic [N_OUT-1:0]   valid_w;
  logic [N_OUT*W-1:0] data_w;

  sel_t               rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   accept_cnt_q, accept_cnt_d;

  // Only the target channel's out_ready reaches in_ready combinationally.
  always_comb begin
    tgt_c      = bus.rr_en ? rr_ptr_q : bus.in_sel;
    in_ready_c = ~valid_w[tgt_c] | bus.out_ready[tgt_c];
    accept_c   = bus.in_valid & in_ready_c;
  end

  for (genvar k = 0; k < int'(N_OUT); k++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept_c && (tgt_c == sel_t'(k))),
      .load_data (bus.in_data),
      .drain     (valid_w[k] & bus.out_ready[k]),
      .valid     (valid_w[k]),
      .data      (data_w[k*W +: W])
    );
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    accept_cnt_d = accept_cnt_q;
    if (accept_c) begin
      accept_cnt_d = accept_cnt_q + CNT_W'(1);
      if (bus.rr_en) rr_ptr_d = rr_ptr_q + sel_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      accept_cnt_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      accept_cnt_q <= accept_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = valid_w;
  assign bus.out_data   = data_w;
  assign bus.rr_ptr     = rr_ptr_q;
  assign bus.accept_cnt = accept_cnt_q;
endmodule

// File: tb/tb_demux1to4_reg.sv
// Directed self-checking bench for demux1to4_reg.
module tb_demux1to4_reg;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  demux1to4_reg_if #(.W(4), .CNT_W(8)) bus ();

  demux1to4_reg #(.W(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (bus.out_valid !== 4'b0000) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0000", bus.out_valid); end
    n_vec++;
    if (bus.out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data got=%h exp=0000", bus.out_data); end
    n_vec++;
    if (bus.rr_ptr !== 2'd0) begin n_err++; $display("FAIL reset_rr_ptr got=%0d exp=0", bus.rr_ptr); end
    n_vec++;
    if (bus.accept_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", bus.accept_cnt); end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_explicit();
    logic [3:0] vals [4];
    vals = '{4'd5, 4'd1, 4'd5, 4'd9};
    bus.rr_en     = 1'b0;
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      send(2'(i), vals[i]);
      #1;
      n_vec++;
      if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL explicit_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      step();
      exp_cnt++;
      n_vec++;
      if (bus.out_valid !== (4'b0001 << i)) begin n_err++; $display("FAIL explicit_valid[%0d] got=%b exp=%b", i, bus.out_valid, 4'b0001 << i); end
      n_vec++;
      if (bus.out_data[i*4 +: 4] !== vals[i]) begin n_err++; $display("FAIL explicit_data[%0d] got=%0d exp=%0d", i, bus.out_data[i*4 +: 4], vals[i]); end
    end
    bus.in_valid = 1'b0;
    step();
    n_vec++;
    if (bus.accept_cnt !== 8'd4) begin n_err++; $display("FAIL explicit_cnt got=%0d exp=4", bus.accept_cnt); end
    n_vec++;
    if (bus.out_valid !== 4'b0000) begin n_err++; $display("FAIL explicit_drained got=%b exp=0000", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 4'b1011;
    send(2'd2, 4'd7);
    step();
    exp_cnt++;
    n_vec++;
    if (bus.out_valid[2] !== 1'b1 || bus.out_data[11:8] !== 4'd7) begin n_err++; $display("FAIL bp_first valid=%b data=%0d exp valid=1 data=7", bus.out_valid[2], bus.out_data[11:8]); end
    send(2'd2, 4'd3);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready got=%b exp=0", bus.in_ready); end
    step();
    n_vec++;
    if (bus.out_data[11:8] !== 4'd7) begin n_err++; $display("FAIL bp_hold got=%0d exp=7", bus.out_data[11:8]); end
    n_vec++;
    if (bus.accept_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL bp_cnt_stall got=%0d exp=%0d", bus.accept_cnt, exp_cnt); end
    send(2'd1, 4'd6);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_other_ready got=%b exp=1", bus.in_ready); end
    step();
    exp_cnt++;
    n_vec++;
    if (bus.out_valid !== 4'b0110 || bus.out_data[7:4] !== 4'd6 || bus.out_data[11:8] !== 4'd7) begin n_err++; $display("FAIL bp_other valid=%b d1=%0d d2=%0d exp valid=0110 d1=6 d2=7", bus.out_valid, bus.out_data[7:4], bus.out_data[11:8]); end
    send(2'd2, 4'd3);
    bus.out_ready = 4'b1111;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    step();
    exp_cnt++;
    n_vec++;
    if (bus.out_valid !== 4'b0100 || bus.out_data[11:8] !== 4'd3) begin n_err++; $display("FAIL bp_replace valid=%b d2=%0d exp valid=0100 d2=3", bus.out_valid, bus.out_data[11:8]); end
    bus.in_valid = 1'b0;
    step();
    n_vec++;
    if (bus.out_valid !== 4'b0000 || bus.out_data[11:8] !== 4'd3) begin n_err++; $display("FAIL bp_drain valid=%b d2=%0d exp valid=0000 d2=3", bus.out_valid, bus.out_data[11:8]); end
    n_vec++;
    if (bus.accept_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL bp_cnt got=%0d exp=%0d", bus.accept_cnt, exp_cnt); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ch [6];
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    bus.rr_en     = 1'b1;
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      send(2'd3, 4'(i + 1));
      step();
      exp_cnt++;
      n_vec++;
      if (bus.out_valid !== (4'b0001 << exp_ch[i]) || bus.out_data[exp_ch[i]*4 +: 4] !== 4'(i + 1))
        begin n_err++; $display("FAIL rr_beat[%0d] valid=%b data=%0d exp valid=%b data=%0d", i, bus.out_valid, bus.out_data[exp_ch[i]*4 +: 4], 4'b0001 << exp_ch[i], i + 1); end
    end
    n_vec++;
    if (bus.rr_ptr !== 2'd2) begin n_err++; $display("FAIL rr_ptr_end got=%0d exp=2", bus.rr_ptr); end
    bus.rr_en = 1'b0;
    send(2'd3, 4'd9);
    step();
    exp_cnt++;
    n_vec++;
    if (bus.rr_ptr !== 2'd2 || bus.out_valid !== 4'b1000) begin n_err++; $display("FAIL rr_hold ptr=%0d valid=%b exp ptr=2 valid=1000", bus.rr_ptr, bus.out_valid); end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_drain_load();
    bus.rr_en     = 1'b0;
    bus.out_ready = 4'b1110;
    send(2'd0, 4'd4);
    step();
    exp_cnt++;
    n_vec++;
    if (bus.out_valid[0] !== 1'b1 || bus.out_data[3:0] !== 4'd4) begin n_err++; $display("FAIL dl_fill valid=%b data=%0d exp valid=1 data=4", bus.out_valid[0], bus.out_data[3:0]); end
    bus.out_ready = 4'b1111;
    send(2'd0, 4'd8);
    step();
    exp_cnt++;
    n_vec++;
    if (bus.out_valid[0] !== 1'b1 || bus.out_data[3:0] !== 4'd8) begin n_err++; $display("FAIL dl_swap valid=%b data=%0d exp valid=1 data=8", bus.out_valid[0], bus.out_data[3:0]); end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_counter_wrap();
    int n;
    n = 256 - exp_cnt;
    bus.rr_en     = 1'b0;
    bus.out_ready = 4'b1111;
    send(2'd0, 4'd1);
    for (int i = 0; i < n; i++) step();
    exp_cnt = 0;
    n_vec++;
    if (bus.accept_cnt !== 8'd0) begin n_err++; $display("FAIL cnt_wrap got=%0d exp=0", bus.accept_cnt); end
    step();
    exp_cnt = 1;
    n_vec++;
    if (bus.accept_cnt !== 8'd1) begin n_err++; $display("FAIL cnt_after_wrap got=%0d exp=1", bus.accept_cnt); end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    bus.rr_en     = 1'b0;
    bus.out_ready = 4'b0000;
    send(2'd1, 4'd2);
    step();
    send(2'd3, 4'd5);
    step();
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 4'b1010) begin n_err++; $display("FAIL ar_prefill got=%b exp=1010", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 4'b0000) begin n_err++; $display("FAIL ar_valid got=%b exp=0000", bus.out_valid); end
    n_vec++;
    if (bus.rr_ptr !== 2'd0 || bus.accept_cnt !== 8'd0) begin n_err++; $display("FAIL ar_regs ptr=%0d cnt=%0d exp ptr=0 cnt=0", bus.rr_ptr, bus.accept_cnt); end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL ar_in_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.rr_en     = 1'b1;
    bus.out_ready = 4'b1111;
    send(2'd3, 4'hA);
    step();
    n_vec++;
    if (bus.out_valid !== 4'b0001 || bus.out_data[3:0] !== 4'hA || bus.rr_ptr !== 2'd1 || bus.accept_cnt !== 8'd1)
      begin n_err++; $display("FAIL ar_first_rr valid=%b d0=%0d ptr=%0d cnt=%0d exp valid=0001 d0=10 ptr=1 cnt=1", bus.out_valid, bus.out_data[3:0], bus.rr_ptr, bus.accept_cnt); end
    bus.in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.rr_en     = 1'b0;
    bus.out_ready = '0;
    test_reset();
    test_explicit();
    test_backpressure();
    test_round_robin();
    test_drain_load();
    test_counter_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
